// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider feeding the register file write port.
// Build option MULDIV_DIV_EN: when undefined the divide datapath is removed and DIVU/REMU complete with 0.
//
// state   | meaning
// --------+-------------------------------------------------------
// ST_IDLE | waiting for start_i; operands latched on start
// ST_RUN  | one multiply/divide iteration per cycle, DATAW cycles
// ST_DONE | result_o valid, done_o/we_o pulse, back to idle
module muldiv_unit #(
    parameter int ADDRW = 5,
    parameter int DATAW = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [DATAW-1:0] opa_i,
    input  logic [DATAW-1:0] opb_i,
    input  logic [ADDRW-1:0] rd_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             we_o,
    output logic [ADDRW-1:0] rd_o,
    output logic [DATAW-1:0] result_o
);

    localparam int CNTW = $clog2(DATAW);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t               state_q, state_d;
    logic [CNTW-1:0]      cnt_q;
    logic [1:0]           op_q;
    logic [DATAW-1:0]     opr_q;
    logic [2*DATAW-1:0]   acc_q, acc_d;
    logic [2*DATAW-1:0]   mul_nxt, div_nxt;
    logic [DATAW:0]       mul_sum;
    logic [DATAW-1:0]     res_d;
    logic                 last_iter;

    assign last_iter = (state_q == ST_RUN) && (cnt_q == CNTW'(DATAW-1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_i) state_d = ST_RUN;
            ST_RUN:  if (last_iter) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef MULDIV_DIV_EN
    logic [DATAW:0] div_shift, div_diff;
    logic           div_ge;
`endif

    // acc holds {product_hi, multiplier} for multiply, {remainder, dividend/quotient} for divide
    always_comb begin
        mul_sum = {1'b0, acc_q[2*DATAW-1:DATAW]} + (acc_q[0] ? {1'b0, opr_q} : (DATAW+1)'(0));
        mul_nxt = {mul_sum, acc_q[DATAW-1:1]};
`ifdef MULDIV_DIV_EN
        div_shift = {acc_q[2*DATAW-1:DATAW], acc_q[DATAW-1]};
        div_diff  = div_shift - {1'b0, opr_q};
        div_ge    = (div_shift >= {1'b0, opr_q});
        div_nxt   = {(div_ge ? div_diff[DATAW-1:0] : div_shift[DATAW-1:0]),
                     acc_q[DATAW-2:0], div_ge};
`else
        div_nxt   = '0;
`endif
        acc_d = op_q[1] ? div_nxt : mul_nxt;
        // MULHU and REMU both take the upper half; MUL and DIVU the lower half
        res_d = op_q[0] ? acc_d[2*DATAW-1:DATAW] : acc_d[DATAW-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            op_q     <= '0;
            opr_q    <= '0;
            acc_q    <= '0;
            rd_o     <= '0;
            result_o <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            we_o     <= 1'b0;
        end else begin
            busy_o <= (state_d != ST_IDLE);
            done_o <= (state_d == ST_DONE);
            we_o   <= (state_d == ST_DONE) && (rd_o != '0);
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        op_q  <= op_i;
                        rd_o  <= rd_i;
                        cnt_q <= '0;
                        opr_q <= op_i[1] ? opb_i : opa_i;
                        acc_q <= {{DATAW{1'b0}}, (op_i[1] ? opa_i : opb_i)};
                    end
                end
                ST_RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_iter) result_o <= res_d;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed vector bench for muldiv_unit: table of operations plus re-start and reset corner sequences.
module tb_muldiv_unit;
    localparam int ADDRW = 5;
    localparam int DATAW = 32;
`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             start_i;
    logic [1:0]       op_i;
    logic [DATAW-1:0] opa_i, opb_i;
    logic [ADDRW-1:0] rd_i;
    logic             busy_o, done_o, we_o;
    logic [ADDRW-1:0] rd_o;
    logic [DATAW-1:0] result_o;

    muldiv_unit #(.ADDRW(ADDRW), .DATAW(DATAW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .op_i(op_i),
        .opa_i(opa_i), .opb_i(opb_i), .rd_i(rd_i), .busy_o(busy_o),
        .done_o(done_o), .we_o(we_o), .rd_o(rd_o), .result_o(result_o)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[15];

    // Called just after a falling edge; returns just after the falling edge where busy_o is first low.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                          input bit repulse);
        int done_cnt = 0, we_cnt = 0, busy_cnt = 0, done_k = -1;
        logic [31:0] res_at = '0;
        logic [4:0]  rd_at = '0;
        start_i = 1'b1; op_i = op; opa_i = a; opb_i = b; rd_i = rd;
        @(posedge clk_i);
        for (int k = 0; k <= DATAW + 1; k++) begin
            @(negedge clk_i);
            if (busy_o) busy_cnt++;
            if (we_o) we_cnt++;
            if (done_o) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
                res_at = result_o;
                rd_at  = rd_o;
            end
            if (repulse && (k == 4 || k == 19)) begin
                start_i = 1'b1; op_i = 2'b01; opa_i = 32'h1111; opb_i = 32'h2222; rd_i = 5'd9;
            end else begin
                start_i = 1'b0; op_i = 2'($urandom); opa_i = $urandom; opb_i = $urandom;
                rd_i = 5'($urandom);
            end
        end
        check({tag, "_done_latency"}, 32'(done_k), 32'(DATAW));
        check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(DATAW + 1));
        check({tag, "_result"}, res_at, exp);
        check({tag, "_rd"}, 32'(rd_at), 32'(rd));
        check({tag, "_we_pulses"}, 32'(we_cnt), (rd != 5'd0) ? 32'd1 : 32'd0);
        check({tag, "_result_hold"}, result_o, exp);
    endtask

    initial begin
        int bad_done = 0, bad_busy = 0;
        rst_ni = 1'b0; start_i = 1'b0; op_i = '0; opa_i = '0; opb_i = '0; rd_i = '0;

        vecs[0]  = '{2'b00, 32'd7,          32'd6,          5'd5,  32'd42};
        vecs[1]  = '{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd1,  32'hFFFF_FFFE};
        vecs[2]  = '{2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2,  32'h0000_0001};
        vecs[3]  = '{2'b01, 32'h8000_0000,  32'd2,          5'd3,  32'd1};
        vecs[4]  = '{2'b00, 32'h0001_0000,  32'h0001_0000,  5'd4,  32'd0};
        vecs[5]  = '{2'b00, 32'hDEAD_BEEF,  32'd1,          5'd6,  32'hDEAD_BEEF};
        vecs[6]  = '{2'b10, 32'd100,        32'd7,          5'd7,  DIV_EN ? 32'd14 : 32'd0};
        vecs[7]  = '{2'b11, 32'd100,        32'd7,          5'd8,  DIV_EN ? 32'd2 : 32'd0};
        vecs[8]  = '{2'b10, 32'h1234,       32'd0,          5'd9,  DIV_EN ? 32'hFFFF_FFFF : 32'd0};
        vecs[9]  = '{2'b11, 32'h1234,       32'd0,          5'd10, DIV_EN ? 32'h1234 : 32'd0};
        vecs[10] = '{2'b10, 32'hFFFF_FFFF,  32'd1,          5'd11, DIV_EN ? 32'hFFFF_FFFF : 32'd0};
        vecs[11] = '{2'b11, 32'hFFFF_FFFF,  32'h10,         5'd12, DIV_EN ? 32'hF : 32'd0};
        vecs[12] = '{2'b10, 32'd7,          32'd100,        5'd13, 32'd0};
        vecs[13] = '{2'b10, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd14, DIV_EN ? 32'd1 : 32'd0};
        vecs[14] = '{2'b00, 32'd3,          32'd3,          5'd0,  32'd9};

        #12;
        check("reset_busy", 32'(busy_o), 32'd0);
        check("reset_done", 32'(done_o), 32'd0);
        check("reset_we", 32'(we_o), 32'd0);
        check("reset_rd", 32'(rd_o), 32'd0);
        check("reset_result", result_o, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        for (int i = 0; i < 15; i++)
            run_op($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd,
                   vecs[i].exp, 1'b0);

        run_op("repulse", 2'b00, 32'd7, 32'd6, 5'd5, 32'd42, 1'b1);
        run_op("rd0_after", 2'b00, 32'd3, 32'd3, 5'd0, 32'd9, 1'b0);

        // Reset asserted mid-divide: outputs must clear at once and no write may follow.
        start_i = 1'b1; op_i = 2'b10; opa_i = 32'd100; opb_i = 32'd7; rd_i = 5'd3;
        @(posedge clk_i);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_i);
            start_i = 1'b0;
        end
        check("midrun_busy", 32'(busy_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_we", 32'(we_o), 32'd0);
        check("rst_rd", 32'(rd_o), 32'd0);
        check("rst_result", result_o, 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int k = 0; k < DATAW + 8; k++) begin
            @(negedge clk_i);
            if (done_o || we_o) bad_done++;
            if (busy_o) bad_busy++;
        end
        check("post_rst_no_done", 32'(bad_done), 32'd0);
        check("post_rst_idle", 32'(bad_busy), 32'd0);
        run_op("fresh_divu", 2'b10, 32'd100, 32'd7, 5'd3, DIV_EN ? 32'd14 : 32'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
